// File: rtl/uart_pkg.sv
// Shared arbiter state encoding and default sizing for the UART transmit arbiter.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_SEND  = 2'd2
    } arb_state_t;

    localparam int          N_REQ_DEFAULT   = 4;
    // Two bit-periods at 10416 clk cycles per bit.
    localparam logic [15:0] TIMEOUT_DEFAULT = 16'd20832;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin priority encoder: first set valid bit at or after ptr, wrapping.
// Zero latency; no flow control of its own.
module rr_picker
    import uart_pkg::*;
#(
    parameter  int N_REQ = N_REQ_DEFAULT,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] valid,
    input  logic [IDX_W-1:0] ptr,
    output logic             any,
    output logic [IDX_W-1:0] idx
);

    int cand;

    // Scan from the farthest slot back towards ptr so the nearest valid one wins.
    always_comb begin
        idx  = '0;
        cand = 0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            cand = (int'(ptr) + i) % N_REQ;
            if (valid[cand[IDX_W-1:0]]) begin
                idx = cand[IDX_W-1:0];
            end
        end
    end

    assign any = |valid;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, frame-atomic arbiter feeding one UART transmitter; byte reaches tx_start 1 cycle after handshake.
// Backpressure: req_ready only for the frame owner, only while tx_busy is low; idle owners time out.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter  int          N_REQ   = N_REQ_DEFAULT,
    parameter  logic [15:0] TIMEOUT = TIMEOUT_DEFAULT,
    localparam int          IDX_W   = $clog2(N_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [8*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]   req_last,
    output logic [N_REQ-1:0]   req_ready,
    output logic               tx_start,
    output logic [7:0]         tx_data,
    input  logic               tx_busy,
    input  logic               tx_done,
    output logic               grant_active,
    output logic [IDX_W-1:0]   grant_id,
    output logic               frame_done,
    output logic               abort_err
);

    arb_state_t       state_q, state_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [15:0]      idle_cnt_q, idle_cnt_d;
    logic             last_q, last_d;
    logic [7:0]       tx_data_d;
    logic             tx_start_d;
    logic             grant_active_d;
    logic [IDX_W-1:0] grant_id_d;
    logic             frame_done_d;
    logic             abort_err_d;

    logic             pick_any;
    logic [IDX_W-1:0] pick_idx;
    logic             own_valid;
    logic             hs;
    logic [IDX_W-1:0] next_ptr;

    rr_picker #(.N_REQ(N_REQ)) u_picker (
        .valid (req_valid),
        .ptr   (rr_ptr_q),
        .any   (pick_any),
        .idx   (pick_idx)
    );

    assign own_valid = req_valid[grant_id];
    assign hs        = (state_q == ST_GRANT) && own_valid && !tx_busy;
    assign req_ready = (hs && rst_n) ? (N_REQ'(1) << grant_id) : '0;
    assign next_ptr  = (grant_id == IDX_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;

    always_comb begin
        state_d        = state_q;
        rr_ptr_d       = rr_ptr_q;
        idle_cnt_d     = idle_cnt_q;
        last_d         = last_q;
        tx_data_d      = tx_data;
        tx_start_d     = 1'b0;
        grant_active_d = grant_active;
        grant_id_d     = grant_id;
        frame_done_d   = 1'b0;
        abort_err_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    grant_active_d = 1'b1;
                    grant_id_d     = pick_idx;
                    idle_cnt_d     = '0;
                    state_d        = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (hs) begin
                    tx_data_d  = req_data[{grant_id, 3'b000} +: 8];
                    last_d     = req_last[grant_id];
                    tx_start_d = 1'b1;
                    idle_cnt_d = '0;
                    state_d    = ST_SEND;
                end else if (!own_valid) begin
                    // An owner that stalls mid-frame is evicted so others are not starved.
                    if (idle_cnt_q + 16'd1 == TIMEOUT) begin
                        abort_err_d    = 1'b1;
                        grant_active_d = 1'b0;
                        rr_ptr_d       = next_ptr;
                        idle_cnt_d     = '0;
                        state_d        = ST_IDLE;
                    end else begin
                        idle_cnt_d = idle_cnt_q + 16'd1;
                    end
                end
            end
            ST_SEND: begin
                if (tx_done) begin
                    if (last_q) begin
                        frame_done_d   = 1'b1;
                        grant_active_d = 1'b0;
                        rr_ptr_d       = next_ptr;
                        state_d        = ST_IDLE;
                    end else begin
                        state_d = ST_GRANT;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            rr_ptr_q     <= '0;
            idle_cnt_q   <= '0;
            last_q       <= 1'b0;
            tx_data      <= 8'h00;
            tx_start     <= 1'b0;
            grant_active <= 1'b0;
            grant_id     <= '0;
            frame_done   <= 1'b0;
            abort_err    <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            idle_cnt_q   <= idle_cnt_d;
            last_q       <= last_d;
            tx_data      <= tx_data_d;
            tx_start     <= tx_start_d;
            grant_active <= grant_active_d;
            grant_id     <= grant_id_d;
            frame_done   <= frame_done_d;
            abort_err    <= abort_err_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: queue-driven requesters, a delayed-done transmitter
// and a frame-level round-robin model checking every transmitted byte.
module tb_uart_tx_arbiter;
    import uart_pkg::*;

    localparam int          N   = 4;
    localparam logic [15:0] TMO = 16'd50;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic           tx_start;
    logic [7:0]     tx_data;
    logic           tx_busy;
    logic           tx_done;
    logic           grant_active;
    logic [1:0]     grant_id;
    logic           frame_done;
    logic           abort_err;

    uart_tx_arbiter #(.N_REQ(N), .TIMEOUT(TMO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .tx_start     (tx_start),
        .tx_data      (tx_data),
        .tx_busy      (tx_busy),
        .tx_done      (tx_done),
        .grant_active (grant_active),
        .grant_id     (grant_id),
        .frame_done   (frame_done),
        .abort_err    (abort_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks   = 0;
    int failures = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        int         cyc;
        int         gid;
        logic [7:0] dat;
    } start_t;

    logic [8:0] rq [N][$];   // bytes still to be offered by each requester
    logic [8:0] mq [N][$];   // reference copy consumed as bytes appear on the line
    start_t     slog [$];
    logic [N-1:0] en;

    int  cyc, done_cnt, busy_hold, tx_delay_min, tx_delay_max;
    bit  inflight, stab, rnd_gap, rnd_busy, model_on, ga_prev;
    int  n_start, n_fdone, n_abort;
    int  grant_cyc, hs_cyc, start_cyc, abort_cyc, txdone_cyc, rdy_busy, rdy_bad;
    int  fdq [$];
    logic [7:0] cur_byte;
    int  m_owner, m_ptr;
    bit  m_last;

    function automatic int log_gid(input int k);
        if (k < slog.size()) return slog[k].gid;
        return -1;
    endfunction

    // Frame-level round robin: the owner is the nearest requester with queued data.
    task automatic model_start();
        logic [8:0] e;
        if (m_owner < 0) begin
            for (int k = 0; k < N; k++) begin
                int c;
                c = (m_ptr + k) % N;
                if (m_owner < 0 && mq[c].size() > 0) m_owner = c;
            end
        end
        if (m_owner >= 0 && mq[m_owner].size() > 0) begin
            e = mq[m_owner].pop_front();
            check_val("model_gid", 32'(grant_id), m_owner);
            check_val("model_dat", 32'(tx_data), 32'(e[7:0]));
            m_last = e[8];
        end else begin
            check_val("model_unexpected_start", 32'(grant_id), 32'hFFFF_FFFF);
        end
    endtask

    task automatic model_fdone();
        check_val("model_fdone_on_last", 32'(m_last), 1);
        if (m_owner >= 0) m_ptr = (m_owner + 1) % N;
        m_owner = -1;
        m_last  = 1'b0;
    endtask

    // Requester and transmitter agents: observe at negedge, then drive the next inputs.
    initial begin
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        tx_busy   = 1'b0;
        tx_done   = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) stab = 1'b0;
            tx_done = 1'b0;
            if (inflight) begin
                if (stab) check_val("tx_data_stable", 32'(tx_data), 32'(cur_byte));
                if (done_cnt <= 1) begin
                    tx_done    = 1'b1;
                    inflight   = 1'b0;
                    stab       = 1'b0;
                    txdone_cyc = cyc;
                end else begin
                    done_cnt--;
                end
            end
            if (tx_start) begin
                slog.push_back('{cyc, int'(grant_id), tx_data});
                n_start++;
                start_cyc = cyc;
                cur_byte  = tx_data;
                stab      = 1'b1;
                inflight  = 1'b1;
                done_cnt  = int'($urandom_range(tx_delay_max, tx_delay_min));
                if (model_on) model_start();
            end
            if (frame_done) begin
                n_fdone++;
                fdq.push_back(cyc);
                if (model_on) model_fdone();
            end
            if (abort_err) begin
                n_abort++;
                abort_cyc = cyc;
            end
            if (grant_active && !ga_prev) grant_cyc = cyc;
            ga_prev = grant_active;

            tx_busy = inflight;
            if (grant_active && busy_hold > 0) begin
                tx_busy = 1'b1;
                busy_hold--;
            end
            if (rnd_busy && $urandom_range(3, 0) == 0) tx_busy = 1'b1;

            for (int i = 0; i < N; i++) begin
                req_valid[i] = en[i] && (rq[i].size() > 0);
                if (rnd_gap && grant_active && int'(grant_id) == i && $urandom_range(3, 0) == 0)
                    req_valid[i] = 1'b0;
                req_data[8*i +: 8] = (rq[i].size() > 0) ? rq[i][0][7:0] : 8'h00;
                req_last[i]        = (rq[i].size() > 0) ? rq[i][0][8] : 1'b0;
            end
            #1;
            if (tx_busy && req_ready != '0) rdy_busy++;
            if ((req_ready & ~req_valid) != '0) rdy_bad++;
            if ((req_ready & ~(grant_active ? (4'b0001 << grant_id) : 4'b0000)) != '0) rdy_bad++;
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    void'(rq[i].pop_front());
                    hs_cyc = cyc;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        repeat (cycles) tick();
        for (int i = 0; i < N; i++) begin
            rq[i].delete();
            mq[i].delete();
        end
        slog.delete();
        fdq.delete();
        en        = '1;
        n_start   = 0;
        n_fdone   = 0;
        n_abort   = 0;
        grant_cyc = 0;
        hs_cyc    = 0;
        start_cyc = 0;
        abort_cyc = 0;
        txdone_cyc = 0;
        rdy_busy  = 0;
        busy_hold = 0;
        rnd_gap   = 1'b0;
        rnd_busy  = 1'b0;
        stab      = 1'b0;
        model_on  = 1'b1;
        m_owner   = -1;
        m_ptr     = 0;
        m_last    = 1'b0;
        rst_n     = 1'b1;
    endtask

    task automatic push_byte(input int r, input bit last, input logic [7:0] dat);
        rq[r].push_back({last, dat});
        mq[r].push_back({last, dat});
    endtask

    task automatic push_frame(input int r, input int len);
        for (int b = 0; b < len; b++) push_byte(r, (b == len - 1), 8'($urandom));
    endtask

    task automatic wait_fdone(input int target, input int budget);
        for (int k = 0; k < budget && n_fdone < target; k++) tick();
    endtask

    initial begin
        rst_n        = 1'b0;
        en           = '1;
        inflight     = 1'b0;
        rdy_bad      = 0;
        tx_delay_min = 2;
        tx_delay_max = 10;
        do_reset(3);

        // Reset state
        check_val("rst_tx_start", 32'(tx_start), 0);
        check_val("rst_tx_data", 32'(tx_data), 0);
        check_val("rst_req_ready", 32'(req_ready), 0);
        check_val("rst_grant_active", 32'(grant_active), 0);
        check_val("rst_grant_id", 32'(grant_id), 0);
        check_val("rst_frame_done", 32'(frame_done), 0);
        check_val("rst_abort_err", 32'(abort_err), 0);

        // Single frame from requester 1 with a slow transmitter
        tx_delay_min = 100;
        tx_delay_max = 100;
        push_byte(1, 1'b0, 8'h55);
        push_byte(1, 1'b1, 8'hA3);
        wait_fdone(1, 400);
        repeat (3) tick();
        check_val("t1_starts", n_start, 2);
        check_val("t1_fdone", n_fdone, 1);
        check_val("t1_byte0", (slog.size() > 0) ? 32'(slog[0].dat) : 32'hFFFF_FFFF, 32'h55);
        check_val("t1_byte1", (slog.size() > 1) ? 32'(slog[1].dat) : 32'hFFFF_FFFF, 32'hA3);
        check_val("t1_gid0", log_gid(0), 1);
        check_val("t1_gid1", log_gid(1), 1);
        check_val("t1_released", 32'(grant_active), 0);

        // Contention between requesters 0 and 2, then pointer check via 0/1/3
        do_reset(3);
        tx_delay_min = 2;
        tx_delay_max = 10;
        push_frame(0, 3);
        push_frame(2, 3);
        wait_fdone(2, 600);
        for (int k = 0; k < 6; k++) check_val("t2_owner", log_gid(k), (k < 3) ? 0 : 2);
        check_val("t2_frame0_first",
                  (fdq.size() > 0 && slog.size() > 3) ? 32'(fdq[0] < slog[3].cyc) : 32'd0, 1);
        push_frame(0, 1);
        push_frame(1, 1);
        push_frame(3, 1);
        wait_fdone(5, 600);
        check_val("t2_ptr_after", log_gid(6), 3);
        check_val("t2_ptr_wrap", log_gid(7), 0);
        check_val("t2_ptr_next", log_gid(8), 1);

        // Mid-frame timeout on requester 3
        do_reset(3);
        model_on     = 1'b0;
        tx_delay_min = 5;
        tx_delay_max = 5;
        push_byte(3, 1'b0, 8'($urandom));
        for (int k = 0; k < 300 && n_abort < 1; k++) tick();
        repeat (3) tick();
        check_val("t3_abort_latency", abort_cyc - txdone_cyc, 51);
        check_val("t3_abort_count", n_abort, 1);
        check_val("t3_no_fdone", n_fdone, 0);
        check_val("t3_starts", n_start, 1);
        check_val("t3_released", 32'(grant_active), 0);
        push_frame(0, 1);
        push_frame(3, 1);
        wait_fdone(2, 300);
        check_val("t3_ptr_zero", log_gid(1), 0);
        check_val("t3_then_3", log_gid(2), 3);

        // Transmitter busy for the first 10 grant cycles
        do_reset(3);
        tx_delay_min = 3;
        tx_delay_max = 3;
        busy_hold    = 10;
        push_frame(0, 1);
        wait_fdone(1, 200);
        check_val("t4_ready_while_busy", rdy_busy, 0);
        check_val("t4_hs_after_busy", hs_cyc - grant_cyc, 10);
        check_val("t4_start_latency", start_cyc - hs_cyc, 1);
        check_val("t4_fdone", n_fdone, 1);

        // Reset while a byte is in flight
        do_reset(3);
        tx_delay_min = 2;
        tx_delay_max = 4;
        push_frame(1, 1);
        wait_fdone(1, 100);
        tx_delay_min = 30;
        tx_delay_max = 30;
        push_byte(2, 1'b0, 8'($urandom_range(255, 1)));
        push_byte(2, 1'b1, 8'($urandom));
        for (int k = 0; k < 50 && n_start < 2; k++) tick();
        repeat (5) tick();
        check_val("t5_pre_grant", 32'(grant_active), 1);
        rst_n = 1'b0;
        tick();
        check_val("t5_tx_start", 32'(tx_start), 0);
        check_val("t5_tx_data", 32'(tx_data), 0);
        check_val("t5_req_ready", 32'(req_ready), 0);
        check_val("t5_grant_active", 32'(grant_active), 0);
        check_val("t5_grant_id", 32'(grant_id), 0);
        check_val("t5_frame_done", 32'(frame_done), 0);
        check_val("t5_abort_err", 32'(abort_err), 0);
        do_reset(2);
        for (int k = 0; k < 60 && inflight; k++) tick();
        repeat (3) tick();
        check_val("t5_spurious_done_sent", 32'(txdone_cyc != 0), 1);
        check_val("t5_no_start", n_start, 0);
        check_val("t5_no_fdone", n_fdone, 0);
        check_val("t5_no_abort", n_abort, 0);
        check_val("t5_idle", 32'(grant_active), 0);
        push_frame(0, 1);
        push_frame(2, 1);
        push_frame(3, 1);
        wait_fdone(3, 300);
        check_val("t5_ptr_zero", log_gid(0), 0);

        // Randomized traffic with valid gaps and busy glitches
        for (int round = 0; round < 3; round++) begin
            int total;
            do_reset(2);
            rnd_gap      = 1'b1;
            rnd_busy     = 1'b1;
            tx_delay_min = 1;
            tx_delay_max = 6;
            total        = 0;
            for (int i = 0; i < N; i++) begin
                int nf;
                nf = int'($urandom_range(3, 0));
                for (int f = 0; f < nf; f++) begin
                    push_frame(i, int'($urandom_range(4, 1)));
                    total++;
                end
            end
            wait_fdone(total, 4000);
            repeat (3) tick();
            check_val("rnd_frames", n_fdone, total);
            check_val("rnd_no_abort", n_abort, 0);
            check_val("rnd_left", rq[0].size() + rq[1].size() + rq[2].size() + rq[3].size()
                                  + mq[0].size() + mq[1].size() + mq[2].size() + mq[3].size(), 0);
        end

        check_val("ready_only_owner", rdy_bad, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
